fifo_write_arbiter: RTL
=======================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQUESTER SHALL default to 4; it is the number of requesters sharing one fifo_queue write port.
REQ-002 Parameter NUM_REQUESTER_WIDTH_IN_BITS SHALL default to 2; it is log2(NUM_REQUESTER).
REQ-003 Parameter SINGLE_ENTRY_WIDTH_IN_BITS SHALL default to 64; it is the payload width per request.
REQ-004 clk_in  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset_in  input  1  reset, asynchronous and active-high.
REQ-006 request_flatted_in  input  NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS  payloads; requester i occupies bits [i*W +: W].
REQ-007 request_valid_flatted_in  input  NUM_REQUESTER  per-requester valid, held until acked.
REQ-008 issue_ack_out  output  NUM_REQUESTER  one-cycle per-requester acceptance pulse.
REQ-009 request_out  output  SINGLE_ENTRY_WIDTH_IN_BITS  payload to fifo_queue request_in.
REQ-010 request_valid_out  output  1  valid to fifo_queue request_valid_in.
REQ-011 issue_ack_in  input  1  acceptance from fifo_queue issue_ack_out.
REQ-012 grant_index_out  output  NUM_REQUESTER_WIDTH_IN_BITS  index of the currently granted requester.
REQ-013 is_busy_out  output  1  high while a grant is held.

Function
REQ-014 The arbiter SHALL implement a two-state FSM, IDLE and BUSY.
REQ-015 In IDLE, if any request_valid_flatted_in bit is set, the arbiter SHALL select the first set index at or after priority_ptr (modulo NUM_REQUESTER), register it as the grant, and move to BUSY on the next edge.
REQ-016 In IDLE, request_valid_out, issue_ack_out and is_busy_out SHALL be 0, and request_out SHALL be all-zero.
REQ-017 In BUSY, request_out SHALL equal the granted slice of request_flatted_in and request_valid_out SHALL equal the granted valid bit, both combinationally.
REQ-018 In BUSY, issue_ack_out[grant] SHALL equal issue_ack_in combinationally, and every other issue_ack_out bit SHALL be 0.
REQ-019 In BUSY, when issue_ack_in is 1 the FSM SHALL return to IDLE and priority_ptr SHALL become grant+1, wrapping from NUM_REQUESTER-1 to 0.
REQ-020 In BUSY, if the granted valid drops without an ack (withdrawal), the FSM SHALL return to IDLE with priority_ptr unchanged.
REQ-021 The grant SHALL never change while in BUSY; requests from other requesters SHALL wait.
REQ-022 There SHALL be exactly one IDLE cycle between consecutive grants, so the minimum grant-to-grant spacing is 2 cycles.
REQ-023 An issue_ack_in asserted while in IDLE SHALL be ignored and SHALL produce no issue_ack_out pulse.
REQ-024 A fifo_queue that is full simply withholds issue_ack_in; the arbiter SHALL hold BUSY indefinitely with no timeout.

Reset
REQ-025 While reset_in is high: state SHALL be IDLE, priority_ptr 0, grant_index_out 0, is_busy_out 0, request_valid_out 0, issue_ack_out 0, and request_out all-zero.
REQ-026 A reset asserted mid-BUSY SHALL drop the grant immediately; the pending request SHALL NOT be acked.

Structure
REQ-027 The FSM state encodings SHALL live in the shared parameters header included by the block.
REQ-028 The round-robin first-set-from-pointer search SHALL be a sub-module named round_robin_priority_encoder.
REQ-029 The top level SHALL instantiate no storage; it sits in front of an unmodified fifo_queue.

Verification
REQ-030 The bench SHALL drive requester 2 alone with valid=1 and data=64'hFFFF_FFFF_FFFF_FFF0, with the FIFO acking in the cycle after BUSY is entered -> grant_index_out=2, the data reaches request_out, issue_ack_out=4'b0100 for exactly 1 cycle, and the next ptr is 3.
REQ-031 The bench SHALL hold all 4 requesters valid with distinct data and ack every BUSY cycle -> grant order 0,1,2,3,0, and the FIFO receives the payloads in that order.
REQ-032 With ptr=3 and requesters 0 and 1 valid, the bench SHALL ack -> requester 0 is granted first (wrap-around), then requester 1.
REQ-033 The bench SHALL fill the FIFO (QUEUE_SIZE=16) until issue_ack_in stays 0 -> the arbiter holds BUSY with a stable grant, and a single consumer read then releases exactly one ack.
REQ-034 The bench SHALL let requester 1 drop valid in BUSY without an ack -> the FSM returns to IDLE, ptr is unchanged, and no ack pulse is seen.
REQ-035 The bench SHALL assert reset_in during BUSY -> all outputs go to 0 asynchronously, and after release the arbiter restarts from requester 0.

Source files
------------

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the fifo_write_arbiter slice: default sizes, FSM
// state encoding and the round-robin pointer increment.
package fifo_write_arbiter_pkg;

    localparam int DEFAULT_NUM_REQUESTER               = 4;
    localparam int DEFAULT_NUM_REQUESTER_WIDTH_IN_BITS = 2;
    localparam int DEFAULT_SINGLE_ENTRY_WIDTH_IN_BITS  = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arbiter_state_t;

    // Index after the one just served, wrapping back to requester 0.
    function automatic int next_index(input int index, input int count);
        return (index >= count - 1) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/round_robin_priority_encoder.sv
// Finds the first set valid bit at or after the priority pointer, wrapping
// around the requester range.
module round_robin_priority_encoder #(
    parameter int NUM_REQUESTER               = 4,
    parameter int NUM_REQUESTER_WIDTH_IN_BITS = 2
) (
    input  logic [NUM_REQUESTER-1:0]               request_valid_in,
    input  logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] priority_ptr_in,
    output logic                                   grant_found_out,
    output logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] grant_index_out
);

    int                                   candidate;
    logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] candidate_index;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_found_out = 1'b0;
        grant_index_out = '0;
        candidate       = 0;
        candidate_index = '0;
        for (int offset = NUM_REQUESTER - 1; offset >= 0; offset--) begin
            candidate = int'(priority_ptr_in) + offset;
            if (candidate >= NUM_REQUESTER) begin
                candidate = candidate - NUM_REQUESTER;
            end
            candidate_index = NUM_REQUESTER_WIDTH_IN_BITS'(candidate);
            if (request_valid_in[candidate_index]) begin
                grant_found_out = 1'b1;
                grant_index_out = candidate_index;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter multiplexing several requesters onto the single write
// port of a fifo_queue; holds one grant until the queue acks or the request is withdrawn.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTER               = DEFAULT_NUM_REQUESTER,
    parameter int NUM_REQUESTER_WIDTH_IN_BITS = DEFAULT_NUM_REQUESTER_WIDTH_IN_BITS,
    parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = DEFAULT_SINGLE_ENTRY_WIDTH_IN_BITS
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [NUM_REQUESTER-1:0]                            request_valid_flatted_in,
    output logic [NUM_REQUESTER-1:0]                            issue_ack_out,
    output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in,
    output logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0]              grant_index_out,
    output logic                                                is_busy_out
);

    arbiter_state_t                         state;
    logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] priority_ptr;
    logic                                   grant_found;
    logic [NUM_REQUESTER_WIDTH_IN_BITS-1:0] next_grant;
    logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]  request_slices [NUM_REQUESTER];

    round_robin_priority_encoder #(
        .NUM_REQUESTER               (NUM_REQUESTER),
        .NUM_REQUESTER_WIDTH_IN_BITS (NUM_REQUESTER_WIDTH_IN_BITS)
    ) priority_encoder (
        .request_valid_in (request_valid_flatted_in),
        .priority_ptr_in  (priority_ptr),
        .grant_found_out  (grant_found),
        .grant_index_out  (next_grant)
    );

    // Grant is frozen while BUSY; a withdrawal leaves the pointer where it was.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state           <= IDLE;
            priority_ptr    <= '0;
            grant_index_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        grant_index_out <= next_grant;
                        state           <= BUSY;
                    end
                end
                BUSY: begin
                    if (issue_ack_in) begin
                        state        <= IDLE;
                        priority_ptr <= NUM_REQUESTER_WIDTH_IN_BITS'(
                            next_index(int'(grant_index_out), NUM_REQUESTER));
                    end else if (!request_valid_flatted_in[grant_index_out]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQUESTER; i++) begin
            request_slices[i] = request_flatted_in[i*SINGLE_ENTRY_WIDTH_IN_BITS +: SINGLE_ENTRY_WIDTH_IN_BITS];
        end
    end

    // The queue-facing handshake is a straight pass-through of the granted lane.
    always_comb begin
        request_out       = '0;
        request_valid_out = 1'b0;
        issue_ack_out     = '0;
        if (state == BUSY) begin
            request_out                    = request_slices[grant_index_out];
            request_valid_out              = request_valid_flatted_in[grant_index_out];
            issue_ack_out[grant_index_out] = issue_ack_in;
        end
    end

    assign is_busy_out = (state == BUSY);

endmodule
